dvp_capture_multi: RTL and testbench

- Parametrised next-generation DVP camera capture front end.
- Samples sensor Vsync/Href/Data on PCLK, suppresses the first frames after reset while the sensor settles, and packs 1 or 2 bus beats into a pixel.
- Generates per-pixel coordinates and measures the dimensions of each captured frame.
- Sits between the sensor pins and downstream pixel processing / frame buffer logic.

---
 rtl/dvp_capture_multi.sv | 171 +++++++++++++++++
 tb/tb_dvp_capture_multi.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/dvp_capture_multi.sv
// DVP camera capture front end: input sampling, start-up frame skip, beat packing,
// pixel coordinates and frame-size measurement. Optional cropping under DVP_CROP_EN.
module dvp_capture_multi #(
  parameter int DW            = 8,
  parameter int BEATS_PER_PIX = 2,
  parameter int SKIP_FRAMES   = 10,
  parameter int ADDR_W        = 12
) (
  input  logic                          PCLK,
  input  logic                          Rst_n,
  input  logic                          Vsync,
  input  logic                          Href,
  input  logic [DW-1:0]                 Data,
  input  logic                          Enable,
`ifdef DVP_CROP_EN
  input  logic [ADDR_W-1:0]             CropX0,
  input  logic [ADDR_W-1:0]             CropY0,
  input  logic [ADDR_W-1:0]             CropW,
  input  logic [ADDR_W-1:0]             CropH,
`endif
  output logic                          ImageState,
  output logic                          DataValid,
  output logic [BEATS_PER_PIX*DW-1:0]   DataPixel,
  output logic                          DataHs,
  output logic                          DataVs,
  output logic [ADDR_W-1:0]             Xaddr,
  output logic [ADDR_W-1:0]             Yaddr,
  output logic [ADDR_W-1:0]             FrameWidth,
  output logic [ADDR_W-1:0]             FrameHeight,
  output logic                          FrameDone
);

  localparam int PW = BEATS_PER_PIX * DW;
  localparam int STAGES = 1;
  localparam logic LAST_PH = 1'(BEATS_PER_PIX - 1);
  localparam logic [ADDR_W-1:0] AMAX = '1;

  typedef enum logic [1:0] {SKIP, ARMED, CAPTURE} state_t;
  state_t state, state_nxt;

  logic vs_r, hs_r, vs_d, hs_d;
  logic [DW-1:0] d_r, first_q;
  logic fs, le, beat, last_beat, capture, raw_px, emit, in_win, row_in, skip_hit, phase;
  logic [7:0] skip_cnt;
  logic [ADDR_W-1:0] x, y, ox, oy, last_w, out_x, out_y, p1_x, p1_y;
  logic [PW-1:0] pix_c, p1_pix;
  logic p1_hs, p1_vs;
  logic [STAGES:0] vld_pipe;

  function automatic logic [ADDR_W-1:0] sat_inc(input logic [ADDR_W-1:0] v);
    return (v == AMAX) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge PCLK or negedge Rst_n) begin
    if (!Rst_n) begin
      vs_r <= 1'b0; hs_r <= 1'b0; d_r <= '0;
      vs_d <= 1'b0; hs_d <= 1'b0;
    end else begin
      vs_r <= Vsync; hs_r <= Href; d_r <= Data;
      vs_d <= vs_r;  hs_d <= hs_r;
    end
  end

  assign fs        = vs_r & ~vs_d;
  assign le        = hs_d & ~hs_r;
  // beats seen while Vsync is high are never packed
  assign beat      = hs_r & ~vs_r;
  assign last_beat = beat && (phase == LAST_PH);
  assign capture   = (state == CAPTURE);
  assign raw_px    = last_beat && capture;
  assign emit      = raw_px && in_win;
  assign skip_hit  = fs && (skip_cnt == 8'(SKIP_FRAMES - 1));

  generate
    if (BEATS_PER_PIX == 2) begin : g_two
      assign pix_c = {first_q, d_r};
    end else begin : g_one
      assign pix_c = d_r;
    end
  endgenerate

`ifdef DVP_CROP_EN
  logic [ADDR_W:0] x_end, y_end;
  assign x_end  = {1'b0, CropX0} + {1'b0, CropW};
  assign y_end  = {1'b0, CropY0} + {1'b0, CropH};
  assign row_in = ({1'b0, y} >= {1'b0, CropY0}) && ({1'b0, y} < y_end);
  assign in_win = row_in && ({1'b0, x} >= {1'b0, CropX0}) && ({1'b0, x} < x_end);
  assign out_x  = x - CropX0;
  assign out_y  = y - CropY0;
`else
  assign row_in = 1'b1;
  assign in_win = 1'b1;
  assign out_x  = x;
  assign out_y  = y;
`endif

  always_comb begin
    state_nxt = state;
    if (fs) begin
      case (state)
        SKIP:    if (skip_hit) state_nxt = ARMED;
        ARMED:   if (Enable)   state_nxt = CAPTURE;
        CAPTURE: if (!Enable)  state_nxt = ARMED;
        default: state_nxt = SKIP;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= SKIP; skip_cnt <= '0; ImageState <= 1'b0;
      FrameWidth <= '0; FrameHeight <= '0; FrameDone <= 1'b0;
    end else begin
      state <= state_nxt;
      if (fs && skip_cnt != 8'hFF) skip_cnt <= skip_cnt + 8'd1;
      if (skip_hit) ImageState <= 1'b1;
      FrameDone <= 1'b0;
      if (fs && capture && oy != '0) begin
        FrameWidth  <= last_w;
        FrameHeight <= oy;
        FrameDone   <= 1'b1;
      end
    end
  end

  // x/y are raw coordinates; ox/oy count only emitted pixels and feed the size report
  always_ff @(posedge PCLK or negedge Rst_n) begin
    if (!Rst_n) begin
      phase <= 1'b0; first_q <= '0;
      x <= '0; y <= '0; ox <= '0; oy <= '0; last_w <= '0;
    end else if (fs) begin
      phase <= 1'b0;
      x <= '0; y <= '0; ox <= '0; oy <= '0;
    end else if (le) begin
      phase <= 1'b0;
      x <= '0; ox <= '0;
      if (x != '0) y <= sat_inc(y);
      if (ox != '0) begin
        oy     <= sat_inc(oy);
        last_w <= ox;
      end
    end else if (beat) begin
      phase <= (phase == LAST_PH) ? 1'b0 : 1'b1;
      if (phase == 1'b0) first_q <= d_r;
      if (raw_px) x <= sat_inc(x);
      if (emit) ox <= sat_inc(ox);
    end
  end

  always_ff @(posedge PCLK or negedge Rst_n) begin
    if (!Rst_n) begin
      vld_pipe <= '0; p1_pix <= '0; p1_x <= '0; p1_y <= '0; p1_hs <= 1'b0; p1_vs <= 1'b0;
      DataPixel <= '0; Xaddr <= '0; Yaddr <= '0; DataHs <= 1'b0; DataVs <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], emit};
      if (emit) begin
        p1_pix <= pix_c; p1_x <= out_x; p1_y <= out_y;
      end
      p1_hs <= hs_r & capture & row_in;
      p1_vs <= vs_r & capture;
      if (vld_pipe[0]) begin
        DataPixel <= p1_pix; Xaddr <= p1_x; Yaddr <= p1_y;
      end
      DataHs <= p1_hs;
      DataVs <= p1_vs;
    end
  end

  assign DataValid = vld_pipe[STAGES];

endmodule

// File: tb/tb_dvp_capture_multi.sv
// Directed frame sequence with random pixel data, checked against a frame-level model.
module tb_dvp_capture_multi;
  localparam int SKIP = 2;

  logic PCLK = 1'b0, Rst_n = 1'b0, Vsync = 1'b0, Href = 1'b0, Enable = 1'b0;
  logic [7:0] Data = '0;
  logic ImageState, DataValid, DataHs, DataVs, FrameDone;
  logic [15:0] DataPixel;
  logic [11:0] Xaddr, Yaddr, FrameWidth, FrameHeight;

  dvp_capture_multi #(.DW(8), .BEATS_PER_PIX(2), .SKIP_FRAMES(SKIP), .ADDR_W(12)) dut (
    .PCLK(PCLK), .Rst_n(Rst_n), .Vsync(Vsync), .Href(Href), .Data(Data), .Enable(Enable),
    .ImageState(ImageState), .DataValid(DataValid), .DataPixel(DataPixel),
    .DataHs(DataHs), .DataVs(DataVs), .Xaddr(Xaddr), .Yaddr(Yaddr),
    .FrameWidth(FrameWidth), .FrameHeight(FrameHeight), .FrameDone(FrameDone));

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  logic [15:0] got_pix[$], exp_pix[$];
  logic [11:0] got_x[$], got_y[$], exp_x[$], exp_y[$];
  int got_cyc[$], exp_cyc[$];
  int hs_cnt = 0, fd_cnt = 0, fd_long = 0;
  logic fd_prev = 1'b0;

  always @(negedge PCLK) begin
    if (DataValid) begin
      got_pix.push_back(DataPixel); got_x.push_back(Xaddr);
      got_y.push_back(Yaddr); got_cyc.push_back(cyc);
    end
    if (DataHs) hs_cnt <= hs_cnt + 1;
    if (FrameDone) fd_cnt <= fd_cnt + 1;
    if (FrameDone && fd_prev) fd_long <= fd_long + 1;
    fd_prev <= FrameDone;
  end

  // frame-level model state
  int fs_cnt = 0, exp_fd = 0, exp_w = 0, exp_h = 0, cur_w = 0, cur_h = 0, hs_exp = 0;
  bit prev_cap = 0, dims_ok = 0;
  int lb[0:15];

  task automatic tick();
    @(posedge PCLK); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic frame(input int nl, input bit dec, input bit en_fs, input bit en_mid,
                       input int abort_line);
    bit cap;
    int px;
    logic [7:0] dv, b0;
    dv = 8'hFF; b0 = '0;
    fs_cnt++;
    if (prev_cap && cur_h > 0) begin
      exp_fd++; exp_w = cur_w; exp_h = cur_h; dims_ok = 1;
    end
    cap = (fs_cnt > SKIP) && en_fs;
    cur_w = 0; cur_h = 0;
    Enable = en_fs; Vsync = 1'b1; Href = 1'b0; tick();
    Href = 1'b1; Data = 8'(($urandom)); tick(); tick();
    Href = 1'b0; tick();
    Vsync = 1'b0; tick(); tick();
    if (cap) hs_exp += 2;
    for (int l = 0; l < nl; l++) begin
      if (l == nl / 2) Enable = en_mid;
      px = 0;
      for (int b = 0; b < lb[l]; b++) begin
        Data = dec ? dv : 8'($urandom);
        dv = dv - 8'd1;
        Href = 1'b1;
        if (b % 2 == 0) b0 = Data;
        else if (cap) begin
          exp_pix.push_back({b0, Data}); exp_x.push_back(12'(px));
          exp_y.push_back(12'(cur_h)); exp_cyc.push_back(cyc);
          px++;
        end
        tick();
        if (l == abort_line && b == 5) begin
          prev_cap = cap;
          return;
        end
      end
      Href = 1'b0; tick(); tick(); tick();
      if (cap) hs_exp += lb[l];
      if (px > 0) begin cur_w = px; cur_h++; end
    end
    prev_cap = cap;
    tick(); tick(); tick();
  endtask

  task automatic check_frame(input string tag, input bit do_hs);
    chk({tag, "_npix"}, 32'(got_pix.size()), 32'(exp_pix.size()));
    while (got_pix.size() > 0 && exp_pix.size() > 0) begin
      chk({tag, "_pix"}, 32'(got_pix.pop_front()), 32'(exp_pix.pop_front()));
      chk({tag, "_x"}, 32'(got_x.pop_front()), 32'(exp_x.pop_front()));
      chk({tag, "_y"}, 32'(got_y.pop_front()), 32'(exp_y.pop_front()));
      chk({tag, "_lat"}, 32'(got_cyc.pop_front() - exp_cyc.pop_front()), 32'd3);
    end
    got_pix.delete(); got_x.delete(); got_y.delete(); got_cyc.delete();
    exp_pix.delete(); exp_x.delete(); exp_y.delete(); exp_cyc.delete();
    chk({tag, "_imgstate"}, 32'(ImageState), 32'(fs_cnt >= SKIP));
    chk({tag, "_fdcnt"}, 32'(fd_cnt), 32'(exp_fd));
    chk({tag, "_fdwidth"}, 32'(fd_long), 32'd0);
    if (dims_ok) begin
      chk({tag, "_fwidth"}, 32'(FrameWidth), 32'(exp_w));
      chk({tag, "_fheight"}, 32'(FrameHeight), 32'(exp_h));
    end
    if (do_hs) chk({tag, "_hscnt"}, 32'(hs_cnt), 32'(hs_exp));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(DataValid), 32'd0);
    chk({tag, "_pixel"}, 32'(DataPixel), 32'd0);
    chk({tag, "_xy"}, 32'({Xaddr, Yaddr}), 32'd0);
    chk({tag, "_dims"}, 32'({FrameWidth, FrameHeight}), 32'd0);
    chk({tag, "_flags"}, 32'({ImageState, FrameDone, DataHs, DataVs}), 32'd0);
  endtask

  initial begin
    tick(); tick();
    chk_all_zero("reset");
    Rst_n = 1'b1; tick();

    for (int l = 0; l < 16; l++) lb[l] = 16;
    frame(12, 1'b0, 1'b1, 1'b1, -1); check_frame("f0_skip", 1'b1);
    frame(12, 1'b0, 1'b1, 1'b1, -1); check_frame("f1_armed", 1'b1);
    frame(12, 1'b1, 1'b1, 1'b1, -1);
    chk("f2_first_pix", 32'(got_pix[0]), 32'h0000FFFE);
    check_frame("f2_pack", 1'b1);

    lb[5] = 15;
    frame(12, 1'b0, 1'b1, 1'b1, -1); check_frame("f3_odd", 1'b1);
    lb[5] = 16;
    frame(12, 1'b0, 1'b0, 1'b1, -1); check_frame("f4_disabled", 1'b1);

    for (int l = 0; l < 6; l++) lb[l] = $urandom_range(2, 20);
    frame(6, 1'b0, 1'b1, 1'b1, -1); check_frame("f5_rand", 1'b1);

    for (int l = 0; l < 16; l++) lb[l] = 16;
    frame(12, 1'b0, 1'b1, 1'b1, 3);
    Rst_n = 1'b0; #1;
    chk_all_zero("midline_reset");
    tick(); tick();
    Href = 1'b0;
    Rst_n = 1'b1;
    fs_cnt = 0; prev_cap = 0; cur_h = 0; cur_w = 0; dims_ok = 0;
    tick();
    got_pix.delete(); got_x.delete(); got_y.delete(); got_cyc.delete();
    exp_pix.delete(); exp_x.delete(); exp_y.delete(); exp_cyc.delete();

    for (int l = 0; l < 4; l++) lb[l] = $urandom_range(2, 20);
    frame(4, 1'b0, 1'b1, 1'b1, -1); check_frame("r0_skip", 1'b0);
    frame(4, 1'b0, 1'b1, 1'b1, -1); check_frame("r1_armed", 1'b0);
    frame(4, 1'b0, 1'b1, 1'b1, -1); check_frame("r2_capture", 1'b0);
    frame(4, 1'b0, 1'b1, 1'b1, -1); check_frame("r3_dims", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
